// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 access encodings, FSM state
// encoding and the access-legality check used at request acceptance.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_RESP = 2'd2,
    ST_ERR  = 2'd3
  } lsu_state_e;

  // Unsigned loads have no store counterpart, so they are illegal with we set.
  function automatic logic lsu_access_err(input logic [2:0] funct3,
                                          input logic       we,
                                          input logic [1:0] offset);
    logic err;
    err = 1'b0;
    case (funct3)
      F3_B:    err = 1'b0;
      F3_H:    err = offset[0];
      F3_W:    err = (offset != 2'b00);
      F3_BU:   err = we;
      F3_HU:   err = we | offset[0];
      default: err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: extracts and extends load data, and merges
// byte/halfword store data into a read word for read-modify-write.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic [1:0]        offset_i,
  input  logic [2:0]        funct3_i,
  input  logic [DATA_W-1:0] store_data_i,
  output logic [DATA_W-1:0] load_data_o,
  output logic [DATA_W-1:0] merged_o
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  assign byte_s = mem_rdata_i[{offset_i, 3'b000} +: 8];
  assign half_s = mem_rdata_i[{offset_i[1], 4'b0000} +: 16];

  always_comb begin
    load_data_o = mem_rdata_i;
    case (funct3_i)
      F3_B:    load_data_o = {{(DATA_W-8){byte_s[7]}}, byte_s};
      F3_BU:   load_data_o = {{(DATA_W-8){1'b0}}, byte_s};
      F3_H:    load_data_o = {{(DATA_W-16){half_s[15]}}, half_s};
      F3_HU:   load_data_o = {{(DATA_W-16){1'b0}}, half_s};
      default: load_data_o = mem_rdata_i;
    endcase
  end

  always_comb begin
    merged_o = mem_rdata_i;
    if (funct3_i[1:0] == 2'b00) begin
      merged_o[{offset_i, 3'b000} +: 8] = store_data_i[7:0];
    end else if (funct3_i[1:0] == 2'b01) begin
      merged_o[{offset_i[1], 4'b0000} +: 16] = store_data_i[15:0];
    end else begin
      merged_o = store_data_i;
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: word-addressed single-port data memory with
// one-cycle read latency; sub-word stores are done as read-modify-write.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic                  req_we,
  input  logic [31:0]           req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [2:0]            req_funct3,
  output logic                  req_ready,
  output logic                  stall,
  output logic                  resp_valid,
  output logic [DATA_W-1:0]     resp_rdata,
  output logic                  resp_err,
  output logic [DM_ADDRESS-1:0] mem_addr,
  output logic                  mem_re,
  output logic                  mem_we,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata
);

  lsu_state_e            state_q, state_d;
  logic                  we_q, we_d;
  logic [2:0]            f3_q, f3_d;
  logic [1:0]            off_q, off_d;
  logic [DM_ADDRESS-1:0] widx_q, widx_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;

  logic                  accept_s;
  logic                  err_s;
  logic                  sw_s;
  logic [DATA_W-1:0]     load_data_s;
  logic [DATA_W-1:0]     merged_s;
  logic                  unused_addr_s;

  // Gating with reset keeps every strobe at its reset value while reset is held.
  assign accept_s      = req_valid && (state_q == ST_IDLE) && !reset;
  assign err_s         = lsu_access_err(req_funct3, req_we, req_addr[1:0]);
  assign sw_s          = req_we && (req_funct3 == F3_W);
  assign unused_addr_s = ^req_addr[31:DM_ADDRESS+2];

  lsu_align #(.DATA_W(DATA_W)) u_align (
    .mem_rdata_i  (mem_rdata),
    .offset_i     (off_q),
    .funct3_i     (f3_q),
    .store_data_i (wdata_q),
    .load_data_o  (load_data_s),
    .merged_o     (merged_s)
  );

  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    f3_d      = f3_q;
    off_d     = off_q;
    widx_d    = widx_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = widx_q;
    mem_wdata = '0;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          we_d     = req_we;
          f3_d     = req_funct3;
          off_d    = req_addr[1:0];
          widx_d   = req_addr[DM_ADDRESS+1:2];
          wdata_d  = req_wdata;
          rdata_d  = '0;
          mem_addr = req_addr[DM_ADDRESS+1:2];
          if (err_s) begin
            state_d = ST_ERR;
          end else if (sw_s) begin
            mem_we    = 1'b1;
            mem_wdata = req_wdata;
            state_d   = ST_RESP;
          end else begin
            mem_re  = 1'b1;
            state_d = ST_RD;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RD: begin
        if (we_q) begin
          mem_we    = 1'b1;
          mem_wdata = merged_s;
          rdata_d   = '0;
        end else begin
          rdata_d = load_data_s;
        end
        state_d = ST_RESP;
      end
      ST_RESP: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      off_q   <= 2'b00;
      widx_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
      widx_q  <= widx_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = (state_q == ST_RESP) || (state_q == ST_ERR);
  assign resp_err   = (state_q == ST_ERR);
  assign resp_rdata = (state_q == ST_RESP) ? rdata_q : '0;
  assign stall      = (req_valid && !resp_valid) || (state_q != ST_IDLE);

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a behavioural one-cycle-latency
// data memory.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_funct3;
  logic        req_ready, stall, resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [8:0]  mem_addr;
  logic        mem_re, mem_we;
  logic [31:0] mem_wdata, mem_rdata;

  logic [31:0] mem [0:511];
  logic [32:0] sb_q [$];
  int          check_cnt = 0;
  int          err_cnt   = 0;
  int          we_seen   = 0;

  load_store_unit #(.DM_ADDRESS(9), .DATA_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_funct3 (req_funct3),
    .req_ready  (req_ready),
    .stall      (stall),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_addr   (mem_addr),
    .mem_re     (mem_re),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
      we_seen       <= we_seen + 1;
    end
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one request and follow it until its response or a 6-cycle budget.
  task automatic run(input string name, input logic we, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input int exp_lat, input logic exp_err, input logic [31:0] exp_rdata,
                     input int exp_re, input int exp_we,
                     input logic [8:0] exp_maddr, input logic [31:0] exp_mwdata);
    int lat = -1;
    int re_cnt = 0;
    int we_cnt = 0;
    logic [8:0]  waddr = '0;
    logic [31:0] wd = '0;
    logic [32:0] e;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    sb_q.push_back({exp_err, exp_rdata});
    for (int c = 0; c < 6 && lat < 0; c++) begin
      #1;
      if (c == 0) chk({name, "_stall"}, {31'd0, stall}, 32'd1);
      if (c == 1) chk({name, "_busy_ready"}, {31'd0, req_ready}, 32'd0);
      if (mem_re && mem_we) chk({name, "_re_we_both"}, 32'd1, 32'd0);
      if (mem_re) begin
        re_cnt++;
        chk({name, "_re_addr"}, {23'd0, mem_addr}, {23'd0, exp_maddr});
      end
      if (mem_we) begin
        we_cnt++;
        waddr = mem_addr;
        wd    = mem_wdata;
      end
      if (resp_valid) begin
        lat = c;
        if (sb_q.size() == 0) begin
          chk({name, "_unexpected_resp"}, 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          chk({name, "_err"}, {31'd0, resp_err}, {31'd0, e[32]});
          chk({name, "_rdata"}, resp_rdata, e[31:0]);
        end
      end
      @(negedge clk);
      req_valid = 1'b0;
    end
    if (lat < 0 && sb_q.size() != 0) e = sb_q.pop_front();
    chk({name, "_latency"}, lat, exp_lat);
    chk({name, "_re_count"}, re_cnt, exp_re);
    chk({name, "_we_count"}, we_cnt, exp_we);
    if (exp_we != 0) begin
      chk({name, "_we_addr"}, {23'd0, waddr}, {23'd0, exp_maddr});
      chk({name, "_we_data"}, wd, exp_mwdata);
    end
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_ready"}, {31'd0, req_ready}, 32'd1);
    chk({name, "_resp_valid"}, {31'd0, resp_valid}, 32'd0);
    chk({name, "_resp_err"}, {31'd0, resp_err}, 32'd0);
    chk({name, "_mem_re"}, {31'd0, mem_re}, 32'd0);
    chk({name, "_mem_we"}, {31'd0, mem_we}, 32'd0);
    chk({name, "_resp_rdata"}, resp_rdata, 32'd0);
    chk({name, "_mem_addr"}, {23'd0, mem_addr}, 32'd0);
    chk({name, "_mem_wdata"}, mem_wdata, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 32'h0;
    mem[5] = 32'h8899AABB;
    mem_rdata = 32'h0;
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0; req_funct3 = 3'b000;
    repeat (2) @(negedge clk);
    chk_reset_outputs("rst");
    reset = 1'b0;

    run("lb15",   1'b0, 3'b000, 32'h15,  32'h0, 2, 1'b0, 32'hFFFFFFAA, 1, 0, 9'd5, 32'h0);
    run("lhu16",  1'b0, 3'b101, 32'h16,  32'h0, 2, 1'b0, 32'h00008899, 1, 0, 9'd5, 32'h0);
    run("lh14",   1'b0, 3'b001, 32'h14,  32'h0, 2, 1'b0, 32'hFFFFAABB, 1, 0, 9'd5, 32'h0);
    run("lbu17",  1'b0, 3'b100, 32'h17,  32'h0, 2, 1'b0, 32'h00000088, 1, 0, 9'd5, 32'h0);
    run("lw14",   1'b0, 3'b010, 32'h14,  32'h0, 2, 1'b0, 32'h8899AABB, 1, 0, 9'd5, 32'h0);
    run("sb17",   1'b1, 3'b000, 32'h17,  32'h11223344, 2, 1'b0, 32'h0, 1, 1, 9'd5, 32'h4499AABB);
    run("lw_sb",  1'b0, 3'b010, 32'h14,  32'h0, 2, 1'b0, 32'h4499AABB, 1, 0, 9'd5, 32'h0);
    run("lw_wrap",1'b0, 3'b010, 32'h814, 32'h0, 2, 1'b0, 32'h4499AABB, 1, 0, 9'd5, 32'h0);
    run("sw20",   1'b1, 3'b010, 32'h20,  32'hDEADBEEF, 1, 1'b0, 32'h0, 0, 1, 9'd8, 32'hDEADBEEF);
    run("sh22",   1'b1, 3'b001, 32'h22,  32'h1234CAFE, 2, 1'b0, 32'h0, 1, 1, 9'd8, 32'hCAFEBEEF);
    run("lh22",   1'b0, 3'b001, 32'h22,  32'h0, 2, 1'b0, 32'hFFFFCAFE, 1, 0, 9'd8, 32'h0);
    run("lw22",   1'b0, 3'b010, 32'h22,  32'h0, 1, 1'b1, 32'h0, 0, 0, 9'd8, 32'h0);
    run("sh23",   1'b1, 3'b001, 32'h23,  32'h0, 1, 1'b1, 32'h0, 0, 0, 9'd8, 32'h0);
    run("f3_011", 1'b0, 3'b011, 32'h20,  32'h0, 1, 1'b1, 32'h0, 0, 0, 9'd8, 32'h0);
    run("sbu",    1'b1, 3'b100, 32'h20,  32'h0, 1, 1'b1, 32'h0, 0, 0, 9'd8, 32'h0);

    // SH accepted, reset lands while the FSM sits in RD.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b001; req_addr = 32'h14; req_wdata = 32'h5555;
    #1;
    chk("rmw_accept_re", {31'd0, mem_re}, 32'd1);
    we_seen = 0;
    @(negedge clk);
    req_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk_reset_outputs("rst_rd");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_rd_no_we", we_seen, 32'd0);
    chk("rst_rd_mem5", mem[5], 32'h4499AABB);
    run("lw_after_rst", 1'b0, 3'b010, 32'h14, 32'h0, 2, 1'b0, 32'h4499AABB, 1, 0, 9'd5, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", check_cnt, err_cnt);
    $finish;
  end

endmodule
